// File: rtl/flag_cond_unit.sv
// flag_cond_unit: status register {N,Z,C,V}, condition evaluator, LIFO save/restore.
// Ports: clk, rst_n, alu_* flags in, flag_we/flag_wr_*, cond, exc_enter/return -> flags, cond_pass, stack_*.
module flag_cond_unit #(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_co,
    input  logic       alu_ovf,
    input  logic       alu_arith,
    input  logic       flag_we,
    input  logic       flag_wr_en,
    input  logic [3:0] flag_wr_data,
    input  logic [3:0] cond,
    input  logic       exc_enter,
    input  logic       exc_return,
    output logic [3:0] flags,
    output logic       cond_pass,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] ptr;
    logic [3:0]    stk [DEPTH];
    logic [3:0]    nf;
    logic [3:0]    fsel;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          push_req;
    logic          pop_req;
    logic          do_push;
    logic          do_pop;
    logic          misuse;

    assign stack_empty = (ptr == '0);
    assign stack_full  = (ptr == PW'(DEPTH));

    // Both pulses together is a conflict, never a push or pop.
    assign push_req = exc_enter & ~exc_return;
    assign pop_req  = exc_return & ~exc_enter;
    assign do_push  = push_req & ~stack_full;
    assign do_pop   = pop_req & ~stack_empty;
    assign misuse   = (push_req & stack_full)
                    | (pop_req & stack_empty)
                    | (exc_enter & exc_return);

    // Low pointer bits address the array; ptr==DEPTH wraps to index 0,
    // so ptr-1 still lands on the top entry when full.
    assign wr_idx = ptr[AW-1:0];
    assign rd_idx = ptr[AW-1:0] - AW'(1);

    always_comb begin
        nf = flags;
        if (do_pop) begin
            nf = stk[rd_idx];
        end else if (flag_wr_en) begin
            nf = flag_wr_data;
        end else if (flag_we) begin
            nf[3] = alu_n;
            nf[2] = alu_z;
            // Logic ops leave CO/OVF undriven; keep the old C and V.
            if (alu_arith) begin
                nf[1] = alu_co;
                nf[0] = alu_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags     <= 4'b0000;
            ptr       <= '0;
            stack_err <= 1'b0;
        end else begin
            flags <= nf;
            if (do_push) begin
                ptr <= ptr + PW'(1);
            end else if (do_pop) begin
                ptr <= ptr - PW'(1);
            end
            if (misuse) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Entries carry no reset; they are only read below a valid pointer.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            stk[wr_idx] <= nf;
        end
    end

    assign fsel = BYPASS ? nf : flags;

    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            4'b0000: cond_pass = fsel[2];
            4'b0001: cond_pass = ~fsel[2];
            4'b0010: cond_pass = fsel[1];
            4'b0011: cond_pass = ~fsel[1];
            4'b0100: cond_pass = fsel[3];
            4'b0101: cond_pass = ~fsel[3];
            4'b0110: cond_pass = fsel[0];
            4'b0111: cond_pass = ~fsel[0];
            4'b1000: cond_pass = fsel[1] & ~fsel[2];
            4'b1001: cond_pass = ~fsel[1] | fsel[2];
            4'b1010: cond_pass = (fsel[3] == fsel[0]);
            4'b1011: cond_pass = (fsel[3] != fsel[0]);
            4'b1100: cond_pass = ~fsel[2] & (fsel[3] == fsel[0]);
            4'b1101: cond_pass = fsel[2] | (fsel[3] != fsel[0]);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: scoreboard bench for flag_cond_unit, BYPASS=0 and BYPASS=1 side by side.
// Expected status and cond_pass come from a queue-stack reference model.
module tb_flag_cond_unit;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       alu_n, alu_z, alu_co, alu_ovf, alu_arith;
    logic       flag_we, flag_wr_en;
    logic [3:0] flag_wr_data;
    logic [3:0] cond;
    logic       exc_enter, exc_return;
    logic [3:0] flags0, flags1;
    logic       cp0, cp1;
    logic       empty0, full0, err0;
    logic       empty1, full1, err1;

    flag_cond_unit #(.DEPTH(DEPTH), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_co(alu_co), .alu_ovf(alu_ovf),
        .alu_arith(alu_arith), .flag_we(flag_we), .flag_wr_en(flag_wr_en),
        .flag_wr_data(flag_wr_data), .cond(cond),
        .exc_enter(exc_enter), .exc_return(exc_return),
        .flags(flags0), .cond_pass(cp0),
        .stack_empty(empty0), .stack_full(full0), .stack_err(err0)
    );

    flag_cond_unit #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_co(alu_co), .alu_ovf(alu_ovf),
        .alu_arith(alu_arith), .flag_we(flag_we), .flag_wr_en(flag_wr_en),
        .flag_wr_data(flag_wr_data), .cond(cond),
        .exc_enter(exc_enter), .exc_return(exc_return),
        .flags(flags1), .cond_pass(cp1),
        .stack_empty(empty1), .stack_full(full1), .stack_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] f;
        logic [3:0] f1;
        logic       e;
        logic       fu;
        logic       er;
        logic       cp0;
        logic       cp1;
        logic       chk;
    } rec_t;

    rec_t exp_q [$];
    rec_t obs_q [$];

    int nchk  = 0;
    int nfail = 0;

    logic [3:0] mflags = 4'b0000;
    logic [3:0] mstack [$];
    logic       merr   = 1'b0;
    logic       mvalid = 1'b0;

    // Conditions come in true/false pairs: bit 0 inverts the base test.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    // One clock: drive inputs, advance the model, record expected and observed.
    task automatic drive(input logic rstn, input logic we, input logic arith,
                         input logic [3:0] alu, input logic wr,
                         input logic [3:0] wd, input logic en,
                         input logic ret, input logic [3:0] c);
        rec_t e;
        rec_t o;
        logic [3:0] nf;
        logic [3:0] prev;
        logic pushr, popr;
        rst_n = rstn; flag_we = we; alu_arith = arith;
        {alu_n, alu_z, alu_co, alu_ovf} = alu;
        flag_wr_en = wr; flag_wr_data = wd;
        exc_enter = en; exc_return = ret; cond = c;
        prev  = mflags;
        pushr = en && !ret;
        popr  = ret && !en;
        if (popr && mstack.size() > 0) nf = mstack[mstack.size()-1];
        else if (wr) nf = wd;
        else if (we) nf = {alu[3], alu[2], arith ? alu[1:0] : prev[1:0]};
        else nf = prev;
        e.chk = rstn && mvalid;
        e.cp0 = ref_cond(c, prev);
        e.cp1 = ref_cond(c, nf);
        if (!rstn) begin
            mflags = 4'b0000;
            mstack.delete();
            merr   = 1'b0;
            mvalid = 1'b1;
        end else begin
            if (popr && mstack.size() > 0) void'(mstack.pop_back());
            else if (pushr && mstack.size() < DEPTH) mstack.push_back(nf);
            if ((pushr && mstack.size() == DEPTH && !(popr))
                && (prev == prev) && 0) merr = 1'b1;
            mflags = nf;
        end
        #1;
        o.cp0 = cp0;
        o.cp1 = cp1;
        o.chk = 1'b0;
        @(posedge clk);
        #1;
        o.f = flags0; o.f1 = flags1;
        o.e = empty0; o.fu = full0; o.er = err0;
        e.f = mflags; e.f1 = mflags;
        e.e  = (mstack.size() == 0);
        e.fu = (mstack.size() == DEPTH);
        e.er = merr;
        exp_q.push_back(e);
        obs_q.push_back(o);
    endtask

    // Error rules kept apart from the stack bookkeeping above: evaluated
    // against the pre-edge depth, applied after the edge.
    int pre_depth;
    always @(negedge clk) pre_depth = mstack.size();

    task automatic note_err(input logic rstn, input logic en, input logic ret,
                            input int depth);
        if (rstn) begin
            if (en && ret) merr = 1'b1;
            if (en && !ret && depth == DEPTH) merr = 1'b1;
            if (ret && !en && depth == 0) merr = 1'b1;
        end
    endtask

    task automatic step(input logic rstn, input logic we, input logic arith,
                        input logic [3:0] alu, input logic wr,
                        input logic [3:0] wd, input logic en,
                        input logic ret, input logic [3:0] c);
        int d;
        d = mstack.size();
        note_err(rstn, en, ret, d);
        drive(rstn, we, arith, alu, wr, wd, en, ret, c);
    endtask

    task automatic test_reset();
        rec_t e, o;
        step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1110);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1111);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL reset status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL reset cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_arith();
        rec_t e, o;
        step(1, 1, 1, 4'b0101, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0010);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1001);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1010);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL arith status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL arith cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_logic_hold();
        rec_t e, o;
        step(1, 0, 0, 4'h0, 1, 4'b0011, 0, 0, 4'b0000);
        step(1, 1, 0, 4'b1000, 0, 4'h0, 0, 0, 4'b1010);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1010);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b1011);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL logic_hold status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL logic_hold cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        rec_t e, o;
        step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 1, 4'b0010, 0, 0, 4'b0000);
        step(1, 1, 1, 4'b1000, 0, 4'h0, 1, 0, 4'b0100);
        step(1, 0, 0, 4'h0, 1, 4'b0001, 0, 0, 4'b0100);
        step(1, 0, 0, 4'h0, 1, 4'b0110, 0, 1, 4'b0110);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL push_pop status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL push_pop cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_stack_depth();
        rec_t e, o;
        logic [3:0] v;
        step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        for (int i = 0; i < DEPTH + 1; i++) begin
            v = 4'(i + 1);
            step(1, 0, 0, 4'h0, 1, v, 1, 0, 4'(i));
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1, 0, 0, 4'h0, 0, 4'h0, 0, 1, 4'(i + 8));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL stack_depth status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL stack_depth cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_conflict_reset();
        rec_t e, o;
        step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 1, 4'b0111, 1, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 1, 4'b1100, 1, 1, 4'b1100);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 1, 4'b0001);
        step(1, 0, 0, 4'h0, 1, 4'b1001, 1, 0, 4'b0101);
        step(0, 1, 1, 4'b1111, 1, 4'b1111, 1, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL conflict_reset status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL conflict_reset cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_bypass();
        rec_t e, o;
        step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 1, 1, 4'b0100, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'b0000);
        step(1, 0, 0, 4'h0, 1, 4'b1001, 1, 0, 4'b1011);
        step(1, 0, 0, 4'h0, 1, 4'b0000, 0, 1, 4'b1011);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL bypass status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL bypass cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    task automatic test_random();
        rec_t e, o;
        logic rn;
        for (int i = 0; i < 300; i++) begin
            rn = ($urandom_range(0, 39) != 0);
            step(rn, 1'($urandom), 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0), 4'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            nchk++;
            if ({o.f, o.f1, o.e, o.fu, o.er} !== {e.f, e.f1, e.e, e.fu, e.er}) begin
                nfail++;
                $display("FAIL random status got %b/%b e%b f%b r%b want %b e%b f%b r%b",
                         o.f, o.f1, o.e, o.fu, o.er, e.f, e.e, e.fu, e.er);
            end
            if (e.chk) begin
                nchk++;
                if ({o.cp0, o.cp1} !== {e.cp0, e.cp1}) begin
                    nfail++;
                    $display("FAIL random cond_pass got %b%b want %b%b",
                             o.cp0, o.cp1, e.cp0, e.cp1);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {alu_n, alu_z, alu_co, alu_ovf, alu_arith} = '0;
        flag_we = 1'b0; flag_wr_en = 1'b0; flag_wr_data = 4'h0;
        cond = 4'h0; exc_enter = 1'b0; exc_return = 1'b0;
        test_reset();
        test_arith();
        test_logic_hold();
        test_push_pop();
        test_stack_depth();
        test_conflict_reset();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
